// File: rtl/ai_sched.sv
// Round-robin scheduler that duty-cycles a shared anomaly-detection engine
// across NCH sensor channels and holds anomaly results until acknowledged.
module ai_sched #(
  parameter int NCH     = 4,
  parameter int DW      = 8,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 64,
  localparam int CW     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sensor_enable,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [NCH*DW-1:0] ch_data,
  output logic [NCH-1:0]    ch_taken,
  output logic              ai_start,
  output logic [DW-1:0]     ai_data,
  output logic [CW-1:0]     ai_ch,
  input  logic              ai_done,
  input  logic [1:0]        ai_result,
  output logic [1:0]        ai_signal,
  output logic [CW-1:0]     result_ch,
  input  logic              ack,
  output logic              alert_pending,
  output logic              sleep,
  output logic              timeout,
  output logic [2:0]        state_dbg
);

  localparam int WW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    SLEEP = 3'd0,
    ARB   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [WW-1:0]   wake_cnt;
  logic [TW-1:0]   to_cnt;
  logic [CW-1:0]   rr_ptr;

  logic            gnt_found;
  logic [CW-1:0]   gnt_idx;
  logic [CW-1:0]   cand;
  logic [CW-1:0]   rr_nx;
  logic [NCH-1:0]  gnt_oh;
  logic [DW-1:0]   gnt_data;
  logic            do_grant;
  logic            wait_to;
  logic [1:0]      res_norm;

  // Handshakes: ch_valid is a level held until the one-cycle ch_taken pulse
  // consumes it; ai_start requests one inference, answered by a one-cycle ai_done.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = CW'((int'(rr_ptr) + k) % NCH);
      if (!gnt_found && ch_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_oh   = '0;
    gnt_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_idx == CW'(k)) begin
        gnt_oh[k] = 1'b1;
        gnt_data  = ch_data[k*DW +: DW];
      end
    end
  end

  assign rr_nx     = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
  assign do_grant  = (state == ARB) && sensor_enable && gnt_found;
  assign wait_to   = (state == WAIT) && !ai_done && (to_cnt == TW'(TIMEOUT - 1));
  assign res_norm  = (ai_result == 2'b11) ? 2'b00 : ai_result;
  assign sleep     = (state == SLEEP);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SLEEP;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SLEEP: if (wake_cnt == '0 && sensor_enable) state_nx = ARB;
      ARB:   state_nx = do_grant ? ISSUE : SLEEP;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (ai_done)      state_nx = (ai_result == 2'b10) ? HOLD : ARB;
        else if (wait_to) state_nx = ARB;
      end
      HOLD:  if (ack) state_nx = ARB;
      default: state_nx = SLEEP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wake_cnt      <= WW'(PERIOD - 1);
      to_cnt        <= '0;
      rr_ptr        <= '0;
      ch_taken      <= '0;
      ai_start      <= 1'b0;
      ai_data       <= '0;
      ai_ch         <= '0;
      ai_signal     <= 2'b00;
      result_ch     <= '0;
      alert_pending <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      ch_taken <= '0;
      ai_start <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        SLEEP: if (wake_cnt != '0) wake_cnt <= wake_cnt - 1'b1;
        ARB: begin
          if (do_grant) begin
            ai_data  <= gnt_data;
            ai_ch    <= gnt_idx;
            rr_ptr   <= rr_nx;
            ai_start <= 1'b1;
            ch_taken <= gnt_oh;
          end else begin
            // Leaving for SLEEP: every sleep period starts from a full count.
            wake_cnt <= WW'(PERIOD - 1);
          end
        end
        ISSUE: to_cnt <= '0;
        WAIT: begin
          if (ai_done) begin
            ai_signal <= res_norm;
            result_ch <= ai_ch;
            if (ai_result == 2'b10) alert_pending <= 1'b1;
          end else if (wait_to) begin
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (ack) begin
            ai_signal     <= 2'b00;
            alert_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ai_sched.md
# ai_sched

Scheduler that shares the single low-power AI anomaly-detection engine between `NCH` sensor channels. It sits between the sensor front-ends and the anomaly FSM. It duty-cycles the engine with a wake timer and round-robin arbitrates pending channel samples into the engine. It then converts engine results into the 2-bit `ai_signal` code the FSM consumes, and holds anomaly results until the FSM acknowledges them.

## Interface
- `NCH`, 4: number of sensor channels (≥2); `CW = $clog2(NCH)`
- `DW`, 8: sample width
- `PERIOD`, 1000: wake interval in cycles spent in SLEEP (≥2)
- `TIMEOUT`, 64: maximum cycles in WAIT before abandoning an inference (≥2)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `sensor_enable`  in  1  FSM permission to sample; low forces a return to SLEEP at the next ARB
- `ch_valid`  in  NCH  per-channel sample ready, level, held until taken
- `ch_data`  in  NCH*DW  packed samples; channel i at bits [i*DW +: DW]
- `ch_taken`  out  NCH  one-hot, one-cycle pulse: sample consumed
- `ai_start`  out  1  one-cycle inference request
- `ai_data`  out  DW  latched sample, valid while `ai_start` is high and through WAIT
- `ai_ch`  out  CW  channel under inference
- `ai_done`  in  1  one-cycle completion pulse from the engine
- `ai_result`  in  2  00 normal, 01 warning, 10 anomaly, 11 reserved (treated as 00)
- `ai_signal`  out  2  result code to the FSM
- `result_ch`  out  CW  channel that produced `ai_signal`
- `ack`  in  1  FSM alert acknowledge
- `alert_pending`  out  1  anomaly held awaiting `ack`
- `sleep`  out  1  engine clock-gate request (high only in SLEEP)
- `timeout`  out  1  one-cycle pulse: inference abandoned

## Operation
- States: SLEEP, ARB, ISSUE, WAIT, HOLD. Reset state is SLEEP, with the wake counter at PERIOD-1.
- Reset values: `ai_signal`=00, `result_ch`=0, `ai_data`=0, `ai_ch`=0, `ch_taken`=0, `ai_start`=0, `alert_pending`=0, `timeout`=0, `sleep`=1, RR pointer=0.
- SLEEP: the wake counter decrements each cycle down to 0 and then holds at 0. When the counter is 0 and `sensor_enable`=1, go to ARB. Every entry into SLEEP reloads the counter to PERIOD-1.
- ARB:
  - If `sensor_enable`=0 or no `ch_valid` bit is set, go to SLEEP.
  - Otherwise grant the first valid channel, searching upward from the RR pointer and wrapping at NCH-1→0.
  - Latch `ch_data` slice into `ai_data` and the channel into `ai_ch`. Set RR pointer = granted+1 mod NCH. Go to ISSUE.
- ISSUE: `ai_start`=1 and `ch_taken[ai_ch]`=1 for exactly this cycle, then go to WAIT. The timeout counter clears. `ai_done` in ISSUE is ignored.
- WAIT:
  - On `ai_done`, register `ai_result` into `ai_signal` (11 maps to 00) and `ai_ch` into `result_ch`.
  - If the result is 10, set `alert_pending` and go to HOLD; otherwise go to ARB.
  - Without `ai_done`, the counter increments. When it reaches TIMEOUT-1 without `ai_done`, pulse `timeout` and go to ARB; `ai_signal` is unchanged.
- HOLD: no new grants. When `ack`=1: `ai_signal`←00, `alert_pending`←0, go to ARB. `ack` is ignored in every other state.
- `ai_signal` holds its last value between results. Non-anomaly results overwrite it freely. An anomaly cannot be overwritten before `ack`.
- One wake serves every pending channel (ARB→…→ARB loop) until none are valid, then returns to SLEEP.
- `sensor_enable` falling mid-transaction does not abort it. The ISSUE/WAIT/HOLD sequence completes; ARB then returns to SLEEP.
- Asserting `reset` in any state immediately restores all reset values. An in-flight inference is dropped, and a late `ai_done` after reset is ignored (state is SLEEP).

## Timing
- All outputs are registered. `sleep` is a decode of the state register.
- Minimum path: counter reaches 0 in SLEEP at cycle N → ARB N+1 → ISSUE N+2 (`ai_start`, `ch_taken`) → WAIT N+3. Earliest `ai_done` is at N+3, giving `ai_signal` updated at N+4.
- Back-to-back channels: ISSUE-to-ISSUE spacing is at least 3 cycles (ISSUE, WAIT, ARB).
- The `ack` that releases HOLD gives `ai_signal`=00 and `alert_pending`=0 on the next edge. An `ack` coincident with the anomaly `ai_done` is ignored.
- Timeout: abandonment occurs exactly TIMEOUT cycles after entering WAIT; `timeout` is high on the first ARB cycle.
- Consecutive wakes with no traffic are spaced PERIOD+1 cycles apart (SLEEP PERIOD cycles plus ARB).

## Test plan
- Reset, PERIOD=8, `sensor_enable`=1, `ch_valid`=0001, `ch_data[7:0]`=0x5A, engine returns 01 with 1-cycle latency. Required: `ai_start` and `ch_taken`=0001 at cycle 10 with `ai_data`=0x5A; `ai_signal`=01 and `result_ch`=0 at cycle 12; then `sleep`=1.
- `ch_valid`=1111 held across grants, RR pointer=2, all results 00. Required: grant order 2,3,0,1; four `ch_taken` pulses; return to SLEEP when `ch_valid`=0.
- Channel 1 returns 10 while channels 2 and 3 are pending. Required: `alert_pending`=1, `ai_signal`=10 held, no `ai_start` until `ack`. `ack` → `ai_signal`=00, then channel 2 is granted.
- Engine never asserts `ai_done`, TIMEOUT=16. Required: `timeout` pulse 16 cycles after entering WAIT, `ai_signal` unchanged, next valid channel granted.
- `sensor_enable`=0 through counter expiry. Required: stay in SLEEP with counter held at 0. Raise `sensor_enable` → ARB on the next cycle.
- Assert `reset` in WAIT, then pulse `ai_done` with result 10. Required: all outputs at reset values, `alert_pending` stays 0.
